dwsep_conv_layer: RTL and testbench

Parametrised depthwise-separable convolution layer: streaming raster-order multi-channel pixel input, per-channel KxK depthwise filter, then IN_CH->OUT_CH pointwise (1x1) combine with bias.
Generalises the fixed 3-channel / 5x5 / 9-output conv2 stage.
Adds runtime-loadable weights, valid/ready backpressure, saturating fixed-point arithmetic, optional ReLU, and end-of-frame marking.
Sits between pooling/activation stages of the CNN pipeline.

---
 rtl/dwsep_pkg.sv | 50 +++++
 rtl/dwsep_window_gen.sv | 77 +++++++
 rtl/dwsep_conv_layer.sv | 212 +++++++++++++++++++++
 tb/tb_dwsep_conv_layer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwsep_pkg.sv
// Shared definitions for the depthwise-separable convolution layer.
// Holds the weight address-map helpers, accumulator width helpers and a
// generic signed saturation function. The localparams give the address map
// at the default geometry (3 in, 9 out, 5x5 kernel). The top recomputes the
// same values from its own parameters through the helper functions.
package dwsep_pkg;

   function automatic int pw_base(input int in_ch, input int k);
      return in_ch * k * k;
   endfunction

   function automatic int bias_base(input int in_ch, input int out_ch, input int k);
      return pw_base(in_ch, k) + out_ch * in_ch;
   endfunction

   function automatic int cfg_aw(input int in_ch, input int out_ch, input int k);
      return $clog2(bias_base(in_ch, out_ch, k) + out_ch);
   endfunction

   // Depthwise accumulator: one full-precision product plus growth for K*K terms
   function automatic int dw_acc_bits(input int data_bits, input int w_bits, input int k);
      return data_bits + w_bits + $clog2(k * k);
   endfunction

   // Pointwise accumulator: extra bit leaves room for the shifted bias term
   function automatic int pw_acc_bits(input int mid_bits, input int w_bits, input int in_ch);
      return mid_bits + w_bits + $clog2(in_ch) + 1;
   endfunction

   // Clamp a signed value to the range of a signed 'bits'-wide word
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

   localparam int DW_BASE   = 0;
   localparam int PW_BASE   = pw_base(3, 5);
   localparam int BIAS_BASE = bias_base(3, 9, 5);
   localparam int CFG_AW    = cfg_aw(3, 9, 5);

endpackage

// File: rtl/dwsep_window_gen.sv
// Per-channel KxK sliding-window generator.
// Ports: clk/rst_n clock and async reset; en shared pipeline enable;
// pix_valid marks an accepted pixel (pix) at raster position (row, col);
// win is the KxK window, flattened as entry (r*K+k) with r=0 the oldest row
// and k=0 the oldest column; win_valid is high when win is a complete
// in-frame window.
module dwsep_window_gen
#(
   parameter int IMG_W     = 12,
   parameter int K         = 5,
   parameter int DATA_BITS = 12,
   parameter int COL_W     = 4,
   parameter int ROW_W     = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       pix_valid,
   input  logic [DATA_BITS-1:0]       pix,
   input  logic [COL_W-1:0]           col,
   input  logic [ROW_W-1:0]           row,
   output logic [K*K*DATA_BITS-1:0]   win,
   output logic                       win_valid
);

   // lb_r[0] holds the previous row and lb_r[K-2] the oldest one
   logic [DATA_BITS-1:0] lb_r  [K-1][IMG_W];
   logic [DATA_BITS-1:0] win_r [K][K];
   logic [DATA_BITS-1:0] col_s [K];
   logic                 win_valid_r;

   // New window column: line-buffer history on top, incoming pixel at the bottom
   always_comb begin
      col_s[K-1] = pix;
      for (int i = 0; i < K - 1; i++) begin
         col_s[i] = lb_r[K-2-i][col];
      end
   end

   // Line buffers and window shift; data only, no reset needed
   always_ff @(posedge clk) begin
      if (en && pix_valid) begin
         lb_r[0][col] <= pix;
         for (int j = 1; j < K - 1; j++) begin
            lb_r[j][col] <= lb_r[j-1][col];
         end
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
               win_r[i][j] <= win_r[i][j+1];
            end
            win_r[i][K-1] <= col_s[i];
         end
      end
   end

   // Window is complete once K-1 rows and K-1 columns precede the new pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid_r <= 1'b0;
      end else if (en) begin
         win_valid_r <= pix_valid && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
      end
   end

   // Flatten the window for the MAC stage
   always_comb begin
      win = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            win[(i*K + j)*DATA_BITS +: DATA_BITS] = win_r[i][j];
         end
      end
   end

   assign win_valid = win_valid_r;

endmodule

// File: rtl/dwsep_conv_layer.sv
// Depthwise-separable convolution layer.
// Streams raster-order multi-channel pixels (in_valid/in_ready/in_data), runs a
// per-channel KxK depthwise filter (stage 1) and an IN_CH->OUT_CH pointwise
// combine with bias and optional ReLU (stage 2), and emits one output vector
// per valid window (out_valid/out_ready/out_data, out_last on the frame's
// final window). Weights are written through cfg_we/cfg_addr/cfg_wdata while
// busy is low. busy covers first accepted pixel to the accepted out_last beat.
module dwsep_conv_layer
   import dwsep_pkg::*;
#(
   parameter int IN_CH     = 3,
   parameter int OUT_CH    = 9,
   parameter int IMG_W     = 12,
   parameter int IMG_H     = 12,
   parameter int K         = 5,
   parameter int DATA_BITS = 12,
   parameter int W_BITS    = 8,
   parameter int MID_BITS  = 14,
   parameter int OUT_BITS  = 16,
   parameter int FRAC_BITS = 6,
   // derived from the geometry; leave at its default
   parameter int CFG_AW    = cfg_aw(IN_CH, OUT_CH, K)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_CH*DATA_BITS-1:0]   in_data,
   input  logic                         relu_en,
   input  logic                         cfg_we,
   input  logic [CFG_AW-1:0]            cfg_addr,
   input  logic [W_BITS-1:0]            cfg_wdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_CH*OUT_BITS-1:0]   out_data,
   output logic                         out_last,
   output logic                         busy
);

   localparam int KK       = K * K;
   localparam int PW_OFS   = pw_base(IN_CH, K);
   localparam int BIAS_OFS = bias_base(IN_CH, OUT_CH, K);
   localparam int N_WTS    = BIAS_OFS + OUT_CH;
   localparam int DW_ACC   = dw_acc_bits(DATA_BITS, W_BITS, K);
   localparam int PW_ACC   = pw_acc_bits(MID_BITS, W_BITS, IN_CH);
   localparam int COL_W    = $clog2(IMG_W);
   localparam int ROW_W    = $clog2(IMG_H);

   logic                            en_s;
   logic                            accept_s;
   logic [COL_W-1:0]                col_r;
   logic [ROW_W-1:0]                row_r;
   logic                            busy_r;
   logic signed [W_BITS-1:0]        wts_r [N_WTS];
   logic [KK*DATA_BITS-1:0]         win_flat_s [IN_CH];
   logic [IN_CH-1:0]                win_valid_s;
   logic                            win_ok_s;
   logic                            last0_r;
   logic signed [DW_ACC-1:0]        dw_acc_s [IN_CH];
   logic signed [MID_BITS-1:0]      mid_s [IN_CH];
   logic signed [MID_BITS-1:0]      mid_r [IN_CH];
   logic                            v1_r;
   logic                            last1_r;
   logic signed [PW_ACC-1:0]        pw_acc_s [OUT_CH];
   logic [OUT_BITS-1:0]             res_s [OUT_CH];
   logic [OUT_CH*OUT_BITS-1:0]      out_s;
   logic                            out_valid_r;
   logic                            out_last_r;
   logic [OUT_CH*OUT_BITS-1:0]      out_data_r;

   // One global stall: the whole pipeline freezes while an output waits
   assign en_s     = !out_valid_r || out_ready;
   assign accept_s = in_valid && en_s;
   assign in_ready = en_s;

   // Raster position of the next pixel; returns to 0 after the frame's last pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         if (col_r == COL_W'(IMG_W - 1)) begin
            col_r <= '0;
            if (row_r == ROW_W'(IMG_H - 1)) begin
               row_r <= '0;
            end else begin
               row_r <= row_r + ROW_W'(1'b1);
            end
         end else begin
            col_r <= col_r + COL_W'(1'b1);
         end
      end
   end

   // Frame-in-progress flag; a next-frame pixel already accepted keeps it set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
      end else if (accept_s) begin
         busy_r <= 1'b1;
      end else if (out_valid_r && out_ready && out_last_r &&
                   col_r == '0 && row_r == '0) begin
         busy_r <= 1'b0;
      end
   end

   // Weight/bias registers; writes are dropped while a frame is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_WTS; i++) begin
            wts_r[i] <= '0;
         end
      end else if (cfg_we && !busy_r && (int'(cfg_addr) < N_WTS)) begin
         wts_r[cfg_addr] <= cfg_wdata;
      end
   end

   for (genvar c = 0; c < IN_CH; c++) begin : g_win
      dwsep_window_gen #(
         .IMG_W     (IMG_W),
         .K         (K),
         .DATA_BITS (DATA_BITS),
         .COL_W     (COL_W),
         .ROW_W     (ROW_W)
      ) u_win (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en_s),
         .pix_valid (accept_s),
         .pix       (in_data[c*DATA_BITS +: DATA_BITS]),
         .col       (col_r),
         .row       (row_r),
         .win       (win_flat_s[c]),
         .win_valid (win_valid_s[c])
      );
   end

   // All channel generators share counters and enable, so their flags agree
   assign win_ok_s = &win_valid_s;

   // Tag the window produced by the frame's final pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last0_r <= 1'b0;
      end else if (en_s) begin
         last0_r <= accept_s && (row_r == ROW_W'(IMG_H - 1)) && (col_r == COL_W'(IMG_W - 1));
      end
   end

   // Depthwise MAC per channel, then shift and clamp to the mid-precision word
   always_comb begin
      for (int c = 0; c < IN_CH; c++) begin
         dw_acc_s[c] = '0;
         for (int i = 0; i < KK; i++) begin
            dw_acc_s[c] = dw_acc_s[c]
               + DW_ACC'($signed(win_flat_s[c][i*DATA_BITS +: DATA_BITS]))
               * DW_ACC'(wts_r[DW_BASE + c*KK + i]);
         end
         mid_s[c] = MID_BITS'(saturate(64'(dw_acc_s[c] >>> FRAC_BITS), MID_BITS));
      end
   end

   // Stage 1 registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r    <= 1'b0;
         last1_r <= 1'b0;
         for (int c = 0; c < IN_CH; c++) begin
            mid_r[c] <= '0;
         end
      end else if (en_s) begin
         v1_r    <= win_ok_s;
         last1_r <= last0_r && win_ok_s;
         for (int c = 0; c < IN_CH; c++) begin
            mid_r[c] <= mid_s[c];
         end
      end
   end

   // Pointwise combine; bias is pre-shifted so it aligns with the product fraction
   always_comb begin
      out_s = '0;
      for (int o = 0; o < OUT_CH; o++) begin
         pw_acc_s[o] = PW_ACC'(wts_r[BIAS_OFS + o]) <<< FRAC_BITS;
         for (int c = 0; c < IN_CH; c++) begin
            pw_acc_s[o] = pw_acc_s[o]
               + PW_ACC'(mid_r[c]) * PW_ACC'(wts_r[PW_OFS + o*IN_CH + c]);
         end
         res_s[o] = OUT_BITS'(saturate(64'(pw_acc_s[o] >>> FRAC_BITS), OUT_BITS));
         out_s[o*OUT_BITS +: OUT_BITS] = (relu_en && res_s[o][OUT_BITS-1]) ? '0 : res_s[o];
      end
   end

   // Stage 2 / output registers; hold while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= '0;
      end else if (en_s) begin
         out_valid_r <= v1_r;
         out_last_r  <= last1_r;
         out_data_r  <= out_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_dwsep_conv_layer.sv
// Self-checking bench for dwsep_conv_layer: a behavioural reference model
// fills a scoreboard queue per frame; a monitor compares every presented
// output against the queue head and pops on each accepted beat.
module tb_dwsep_conv_layer;

   localparam int IN_CH = 3, OUT_CH = 9, IMG_W = 12, IMG_H = 12, K = 5;
   localparam int DATA_BITS = 12, W_BITS = 8, MID_BITS = 14, OUT_BITS = 16, FRAC_BITS = 6;
   localparam int PWB  = IN_CH * K * K;
   localparam int BB   = PWB + OUT_CH * IN_CH;
   localparam int NW   = BB + OUT_CH;
   localparam int AW   = 7;
   localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         in_valid;
   logic                         in_ready;
   logic [IN_CH*DATA_BITS-1:0]   in_data;
   logic                         relu_en;
   logic                         cfg_we;
   logic [AW-1:0]                cfg_addr;
   logic [W_BITS-1:0]            cfg_wdata;
   logic                         out_valid;
   logic                         out_ready;
   logic [OUT_CH*OUT_BITS-1:0]   out_data;
   logic                         out_last;
   logic                         busy;

   typedef struct {
      logic [OUT_CH*OUT_BITS-1:0] data;
      logic                       last;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          wt [NW];
   int          pix [IN_CH][IMG_H][IMG_W];
   int          out_cnt = 0;
   bit          bp_mode = 1'b0;
   bit          gap_mode = 1'b0;
   bit          first_pending = 1'b0;
   longint      t_acc52 = 0;
   longint      t_first = 0;
   logic [15:0] first_ch0 = 16'd0;

   dwsep_conv_layer u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .relu_en   (relu_en),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sat_model(input longint v, input int bits);
      longint hi;
      hi = (longint'(1) << (bits - 1)) - 1;
      if (v > hi) return hi;
      if (v < -hi - 1) return -hi - 1;
      return v;
   endfunction

   // Reference model: push every window's expected vector for the current frame
   function automatic void push_expected(input bit relu);
      exp_t   e;
      longint acc;
      longint mid [IN_CH];
      for (int r0 = 0; r0 <= IMG_H - K; r0++) begin
         for (int c0 = 0; c0 <= IMG_W - K; c0++) begin
            for (int ch = 0; ch < IN_CH; ch++) begin
               acc = 0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     acc += longint'(pix[ch][r0+i][c0+j]) * longint'(wt[ch*K*K + i*K + j]);
               mid[ch] = sat_model(acc >>> FRAC_BITS, MID_BITS);
            end
            e.data = '0;
            for (int o = 0; o < OUT_CH; o++) begin
               acc = longint'(wt[BB + o]) * (longint'(1) << FRAC_BITS);
               for (int ch = 0; ch < IN_CH; ch++)
                  acc += mid[ch] * longint'(wt[PWB + o*IN_CH + ch]);
               acc = sat_model(acc >>> FRAC_BITS, OUT_BITS);
               if (relu && acc < 0) acc = 0;
               e.data[o*OUT_BITS +: OUT_BITS] = acc[OUT_BITS-1:0];
            end
            e.last = (r0 == IMG_H - K) && (c0 == IMG_W - K);
            exp_q.push_back(e);
         end
      end
   endfunction

   // Output monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_value("spurious_out", 256'(out_valid), 256'(1'b0));
            end else begin
               check_value("out_data", 256'(out_data), 256'(exp_q[0].data));
               check_value("out_last", 256'(out_last), 256'(exp_q[0].last));
               if (first_pending) begin
                  t_first       = $time;
                  first_ch0     = out_data[15:0];
                  first_pending = 1'b0;
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  out_cnt++;
               end
            end
         end
      end
   end

   // Downstream ready: random low bursts of 1..10 cycles in backpressure mode
   initial begin
      int stall_left;
      stall_left = 0;
      out_ready  = 1'b1;
      forever begin
         @(negedge clk);
         if (bp_mode) begin
            if (stall_left == 0 && $urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 10);
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic load_weights();
      for (int a = 0; a < NW; a++) begin
         cfg_we    = 1'b1;
         cfg_addr  = AW'(a);
         cfg_wdata = W_BITS'(wt[a]);
         @(negedge clk);
      end
      cfg_we    = 1'b1;
      cfg_addr  = 7'd127;
      cfg_wdata = 8'h55;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic drive_pixels(input int npix, input bit poke);
      for (int p = 0; p < npix; p++) begin
         int r;
         int c;
         int guard;
         r = p / IMG_W;
         c = p % IMG_W;
         if (gap_mode) repeat ($urandom_range(0, 3)) @(negedge clk);
         in_valid = 1'b1;
         for (int ch = 0; ch < IN_CH; ch++)
            in_data[ch*DATA_BITS +: DATA_BITS] = DATA_BITS'(pix[ch][r][c]);
         if (poke && p == 70) begin
            cfg_we    = 1'b1;
            cfg_addr  = 7'd12;
            cfg_wdata = 8'h80;
         end
         guard = 0;
         #1;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
         end
         if (!in_ready) check_value("in_ready_timeout", 256'(in_ready), 256'(1'b1));
         @(posedge clk);
         if (p == 52) t_acc52 = $time;
         @(negedge clk);
         in_valid = 1'b0;
         cfg_we   = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check_value("drain_queue", 256'(exp_q.size()), 256'(0));
      @(negedge clk);
      #3;
      check_value("out_count", 256'(out_cnt), 256'(NOUT));
      check_value("busy_idle", 256'(busy), 256'(1'b0));
      @(negedge clk);
   endtask

   task automatic run_frame(input bit relu, input bit poke);
      relu_en       = relu;
      out_cnt       = 0;
      first_pending = 1'b1;
      push_expected(relu);
      drive_pixels(IMG_W * IMG_H, poke);
      wait_drain();
   endtask

   task automatic apply_reset(input string where);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_value({where, "_out_valid"}, 256'(out_valid), 256'(1'b0));
      check_value({where, "_out_last"},  256'(out_last),  256'(1'b0));
      check_value({where, "_out_data"},  256'(out_data),  256'(0));
      check_value({where, "_busy"},      256'(busy),      256'(1'b0));
      check_value({where, "_in_ready"},  256'(in_ready),  256'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_identity();
      for (int a = 0; a < NW; a++) wt[a] = 0;
      for (int c = 0; c < IN_CH; c++) wt[c*K*K + (K/2)*K + K/2] = 64;
      for (int o = 0; o < 3; o++) wt[PWB + o*IN_CH + o] = 64;
   endtask

   task automatic set_pixels(input int mode);
      for (int ch = 0; ch < IN_CH; ch++)
         for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
               case (mode)
                  0:       pix[ch][r][c] = (ch == 0) ? r*IMG_W + c : 0;
                  1:       pix[ch][r][c] = 2047;
                  2:       pix[ch][r][c] = 0;
                  default: pix[ch][r][c] = int'($urandom_range(0, 4095)) - 2048;
               endcase
   endtask

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      relu_en   = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply_reset("reset");

      // Identity frame with a locked-out config write mid-frame
      set_identity();
      set_pixels(0);
      load_weights();
      run_frame(1'b0, 1'b1);
      check_value("first_ch0", 256'(first_ch0), 256'(26));
      check_value("latency", 256'(t_first - t_acc52), 256'(27));

      // Saturation
      for (int a = 0; a < NW; a++) wt[a] = (a < BB) ? 127 : 0;
      set_pixels(1);
      load_weights();
      run_frame(1'b0, 1'b0);

      // ReLU off and on with negative bias
      set_identity();
      wt[BB] = -128;
      set_pixels(2);
      load_weights();
      run_frame(1'b0, 1'b0);
      run_frame(1'b1, 1'b0);

      // Random data and weights under backpressure and input gaps
      for (int a = 0; a < NW; a++) wt[a] = int'($urandom_range(0, 255)) - 128;
      set_pixels(3);
      load_weights();
      bp_mode  = 1'b1;
      gap_mode = 1'b1;
      run_frame(1'b0, 1'b0);
      bp_mode  = 1'b0;
      gap_mode = 1'b0;

      // Mid-frame reset: partial frame discarded, weights cleared
      set_identity();
      set_pixels(0);
      load_weights();
      relu_en = 1'b0;
      drive_pixels(30, 1'b0);
      #3;
      check_value("busy_mid", 256'(busy), 256'(1'b1));
      apply_reset("midreset");
      for (int a = 0; a < NW; a++) wt[a] = 0;
      run_frame(1'b0, 1'b0);
      set_identity();
      load_weights();
      run_frame(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
